// File: rtl/fpu_out_arb.sv
// FPU output arbiter and CPX request stage.
// Picks one of NUM_PIPES result requests per cycle. High-priority pipes win by
// fixed priority, the others share by round-robin, and a starvation counter
// periodically forces a round-robin grant past high-priority traffic. The
// winner is registered into the CQ stage and acknowledged via dest_rdy.
module fpu_out_arb #(
  parameter int                   NUM_PIPES    = 3,
  parameter int                   ID_W         = 10,
  parameter int                   THR_W        = 2,
  parameter logic [NUM_PIPES-1:0] HP_MASK      = 3'b100,
  parameter int                   STARVE_LIMIT = 4
) (
  input  logic                      rclk,
  input  logic                      reset,
  input  logic [NUM_PIPES-1:0]      pipe_req_in,
  input  logic [NUM_PIPES*ID_W-1:0] pipe_id_in,
  input  logic                      cpx_stall,
  output logic [ID_W-THR_W-1:0]     fp_cpx_req_cq,
  output logic [THR_W-1:0]          req_thread,
  output logic                      req_vld,
  output logic [NUM_PIPES-1:0]      dest_rdy
);

  localparam int PTR_W = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;
  localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_PIPES - 1);
  localparam logic [CNT_W-1:0] LIM      = CNT_W'(STARVE_LIMIT);

  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     starve_cnt_q, starve_cnt_d;
  logic [NUM_PIPES-1:0] cand, hp, rr, sel;
  logic [PTR_W-1:0]     rr_win, hp_win, idx;
  logic                 rr_found, force_rr, rr_grant, hp_grant;
  logic [ID_W-1:0]      out_id;
  int                   pos;

  // Candidate split, round-robin search, priority selection and next state
  always_comb begin
    cand         = cpx_stall ? '0 : pipe_req_in;
    hp           = cand & HP_MASK;
    rr           = cand & ~HP_MASK;
    rr_win       = '0;
    rr_found     = 1'b0;
    hp_win       = '0;
    idx          = '0;
    pos          = 0;
    sel          = '0;
    rr_grant     = 1'b0;
    hp_grant     = 1'b0;
    rr_ptr_d     = rr_ptr_q;
    starve_cnt_d = starve_cnt_q;
    out_id       = '0;

    // Ascending search from rr_ptr with wrap; HP pipes are never in rr.
    for (int k = 0; k < NUM_PIPES; k++) begin
      pos = int'(rr_ptr_q) + k;
      if (pos >= NUM_PIPES) pos = pos - NUM_PIPES;
      idx = PTR_W'(pos);
      if (!rr_found && rr[idx]) begin
        rr_found = 1'b1;
        rr_win   = idx;
      end
    end

    // Lowest set bit of hp wins: scan downward so the last hit is the lowest.
    for (int i = NUM_PIPES - 1; i >= 0; i--) begin
      if (hp[i]) hp_win = PTR_W'(i);
    end

    force_rr = (STARVE_LIMIT != 0) && (starve_cnt_q == LIM) && (|rr);

    if (force_rr) begin
      sel[rr_win] = 1'b1;
      rr_grant    = 1'b1;
    end else if (|hp) begin
      sel[hp_win] = 1'b1;
      hp_grant    = 1'b1;
    end else if (|rr) begin
      sel[rr_win] = 1'b1;
      rr_grant    = 1'b1;
    end

    if (rr_grant) begin
      rr_ptr_d     = (rr_win == LAST_PTR) ? '0 : rr_win + 1'b1;
      starve_cnt_d = '0;
    end else if (hp_grant && (|rr) && (starve_cnt_q != LIM)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end

    for (int i = 0; i < NUM_PIPES; i++) begin
      out_id = out_id | ({ID_W{sel[i]}} & pipe_id_in[i*ID_W +: ID_W]);
    end
  end

  // Arbitration state and CQ-stage output registers
  always_ff @(posedge rclk) begin
    if (reset) begin
      rr_ptr_q      <= '0;
      starve_cnt_q  <= '0;
      dest_rdy      <= '0;
      req_vld       <= 1'b0;
      fp_cpx_req_cq <= '0;
      req_thread    <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      starve_cnt_q  <= starve_cnt_d;
      dest_rdy      <= sel;
      req_vld       <= |sel;
      fp_cpx_req_cq <= out_id[ID_W-1:THR_W];
      req_thread    <= out_id[THR_W-1:0];
    end
  end

endmodule

// File: tb/tb_fpu_out_arb.sv
// Testbench for fpu_out_arb: a default 3-pipe instance and a 5-pipe instance.
// Directed vectors push hand-computed expectations into per-instance queues;
// monitors pop and compare one entry per registered output cycle.
module tb_fpu_out_arb;

  typedef struct {
    logic [7:0] dest;
    logic       vld;
    logic [7:0] cq;
    logic [1:0] thr;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst3 = 1'b1, rst5 = 1'b1;
  logic [2:0]  req3 = '0;
  logic [4:0]  req5 = '0;
  logic        stall3 = 1'b0, stall5 = 1'b0;
  logic [9:0]  id3 [0:7];
  logic [9:0]  id5 [0:7];
  logic [29:0] pid3;
  logic [49:0] pid5;

  logic [7:0] cq3, cq5;
  logic [1:0] thr3, thr5;
  logic       vld3, vld5;
  logic [2:0] dr3;
  logic [4:0] dr5;

  exp_t q3[$];
  exp_t q5[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  assign pid3 = {id3[2], id3[1], id3[0]};
  assign pid5 = {id5[4], id5[3], id5[2], id5[1], id5[0]};

  fpu_out_arb u_dut3 (
    .rclk(clk), .reset(rst3), .pipe_req_in(req3), .pipe_id_in(pid3),
    .cpx_stall(stall3), .fp_cpx_req_cq(cq3), .req_thread(thr3),
    .req_vld(vld3), .dest_rdy(dr3)
  );

  fpu_out_arb #(
    .NUM_PIPES(5), .ID_W(10), .THR_W(2), .HP_MASK(5'b10000), .STARVE_LIMIT(4)
  ) u_dut5 (
    .rclk(clk), .reset(rst5), .pipe_req_in(req5), .pipe_id_in(pid5),
    .cpx_stall(stall5), .fp_cpx_req_cq(cq5), .req_thread(thr5),
    .req_vld(vld5), .dest_rdy(dr5)
  );

  // Apply one cycle of stimulus to instance d and queue its expected output.
  task automatic drv(input int d, input logic r, input logic [7:0] req,
                     input logic st, input logic [7:0] e);
    exp_t       x;
    logic [9:0] id;
    @(negedge clk);
    id = '0;
    for (int i = 0; i < 8; i++) if (e[i]) id = (d == 3) ? id3[i] : id5[i];
    x.dest = e;
    x.vld  = |e;
    x.cq   = id[9:2];
    x.thr  = id[1:0];
    if (d == 3) begin
      rst3 = r; req3 = req[2:0]; stall3 = st; rst5 = 1'b1;
      q3.push_back(x);
    end else begin
      rst5 = r; req5 = req[4:0]; stall5 = st; rst3 = 1'b1;
      q5.push_back(x);
    end
  endtask

  // Monitor for the 3-pipe instance
  always begin
    exp_t x;
    @(posedge clk);
    #1;
    if (q3.size() > 0) begin
      x = q3.pop_front();
      n_tests++;
      if (dr3 !== x.dest[2:0] || vld3 !== x.vld || cq3 !== x.cq || thr3 !== x.thr) begin
        n_fail++;
        $display("FAIL p3 t=%0t: got dest=%b vld=%b cq=%h thr=%b, need dest=%b vld=%b cq=%h thr=%b",
                 $time, dr3, vld3, cq3, thr3, x.dest[2:0], x.vld, x.cq, x.thr);
      end
    end
  end

  // Monitor for the 5-pipe instance
  always begin
    exp_t x;
    @(posedge clk);
    #1;
    if (q5.size() > 0) begin
      x = q5.pop_front();
      n_tests++;
      if (dr5 !== x.dest[4:0] || vld5 !== x.vld || cq5 !== x.cq || thr5 !== x.thr) begin
        n_fail++;
        $display("FAIL p5 t=%0t: got dest=%b vld=%b cq=%h thr=%b, need dest=%b vld=%b cq=%h thr=%b",
                 $time, dr5, vld5, cq5, thr5, x.dest[4:0], x.vld, x.cq, x.thr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, need completion");
    $fatal(1, "timeout");
  end

  initial begin
    id3[0] = 10'h3F5; id3[1] = 10'h2A6; id3[2] = 10'h155;
    id5[0] = 10'h001; id5[1] = 10'h0C2; id5[2] = 10'h203;
    id5[3] = 10'h344; id5[4] = 10'h3FF;
    for (int i = 3; i < 8; i++) id3[i] = '0;
    for (int i = 5; i < 8; i++) id5[i] = '0;

    // Reset with all requests high: no grant, then HP pipe 2 wins first
    drv(3, 1, 8'b111, 0, 8'b000);
    drv(3, 1, 8'b111, 0, 8'b000);
    drv(3, 0, 8'b111, 0, 8'b100);

    // Mid-operation reset discards the grant; then round-robin 0/1
    drv(3, 1, 8'b011, 0, 8'b000);
    for (int i = 0; i < 3; i++) begin
      drv(3, 0, 8'b011, 0, 8'b001);
      drv(3, 0, 8'b011, 0, 8'b010);
    end

    // Starvation guard: HP x4 then forced pipe 0, period 5
    drv(3, 1, 8'b101, 0, 8'b000);
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 4; i++) drv(3, 0, 8'b101, 0, 8'b100);
      drv(3, 0, 8'b101, 0, 8'b001);
    end
    drv(3, 0, 8'b101, 0, 8'b100);

    // Stall: 3 suppressed cycles, pointer resumes at pipe 1
    drv(3, 1, 8'b011, 0, 8'b000);
    drv(3, 0, 8'b011, 0, 8'b001);
    for (int i = 0; i < 3; i++) drv(3, 0, 8'b011, 1, 8'b000);
    drv(3, 0, 8'b011, 0, 8'b010);
    drv(3, 0, 8'b011, 0, 8'b001);

    // Single one-cycle requester, then idle with zero IDs
    drv(3, 1, 8'b000, 0, 8'b000);
    drv(3, 0, 8'b010, 0, 8'b010);
    drv(3, 0, 8'b000, 0, 8'b000);
    drv(3, 0, 8'b000, 0, 8'b000);

    // Five-pipe instance: grant order 0,2,3 repeating, then HP pipe 4
    drv(5, 1, 8'b01101, 0, 8'b00000);
    for (int i = 0; i < 2; i++) begin
      drv(5, 0, 8'b01101, 0, 8'b00001);
      drv(5, 0, 8'b01101, 0, 8'b00100);
      drv(5, 0, 8'b01101, 0, 8'b01000);
    end
    drv(5, 0, 8'b11101, 0, 8'b10000);
    drv(5, 0, 8'b00000, 0, 8'b00000);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
